mul_seq_ctrl: RTL

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

---
 rtl/mul_seq_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl -- sequential shift-and-add multiplier controller.
//
// Drives an external combinational ALU (ADD opcode only) to form the
// unsigned product mul_a*mul_b over N ADD cycles. If either operand is
// zero, the ALU is skipped entirely.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   in_valid/in_ready  operand handshake (in_ready high only in IDLE)
//   mul_a, mul_b       N-bit unsigned operands, captured on accept
//   out_valid/out_ready product handshake (out_valid high only in DONE)
//   product            2N-bit {acc,q}; meaningful only while out_valid
//   busy               high in any state other than IDLE
//   a_o, b_o, sel_o    ALU operands and opcode (ADD = 3'b000)
//   s, carry           ALU sum and carry-out
//   zero, overflow     ALU flags, not used here
//   state_dbg          current FSM state (0=IDLE, 1=ADD, 2=DONE)
//
// Handshake: a transfer happens on a rising clk edge where valid and
// ready are both high. in_ready and out_valid are registered and never
// depend combinationally on in_valid / out_ready. Once out_valid is
// high, product holds steady until the edge on which out_ready is seen.
//
// N must be at least 2: each ADD step drops the sum LSB into q.

module mul_seq_ctrl #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   mul_a,
  input  logic [N-1:0]   mul_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic [N-1:0]   a_o,
  output logic [N-1:0]   b_o,
  output logic [2:0]     sel_o,
  input  logic [N-1:0]   s,
  input  logic           carry,
  input  logic           zero,
  input  logic           overflow,
  output logic [1:0]     state_dbg
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [2:0] OP_ADD = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  acc;
  logic [N-1:0]  q;
  logic [N-1:0]  m;
  logic [CW-1:0] cnt;

  // ALU flags carry no information this block needs.
  logic unused_flags;
  assign unused_flags = zero ^ overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      q         <= '0;
      m         <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            acc      <= '0;
            if (mul_a != '0 && mul_b != '0) begin
              m     <= mul_a;
              q     <= mul_b;
              cnt   <= '0;
              state <= ADD;
            end else begin
              // Zero operand: product is known to be zero, skip the ALU.
              q         <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        ADD: begin
          // Shift the (carry,sum) pair right by one into {acc,q}; q's
          // consumed LSB falls off the bottom as the product's low half
          // fills in from the top.
          acc <= {carry, s[N-1:1]};
          q   <= {s[0], q[N-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // ALU operands are only driven during ADD; otherwise held at zero.
  always_comb begin
    a_o = '0;
    b_o = '0;
    if (state == ADD) begin
      a_o = acc;
      b_o = q[0] ? m : '0;
    end
  end

  assign sel_o     = OP_ADD;
  assign product   = {acc, q};
  assign state_dbg = state;

endmodule
